// File: rtl/soc_fpga_ram_code_loader.sv
// Code RAM loader: packs a host byte stream little-endian into RAM words and writes
// them to consecutive addresses, reporting a 16-bit byte checksum and a Done pulse.
// Optional read-back verify pass is enabled by defining LOADER_VERIFY_EN.
module soc_fpga_ram_code_loader #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 14
) (
    input  logic                 PortAClk,
    input  logic                 PortAReset,
    input  logic                 StartLoad,
    input  logic [ADDRWIDTH-1:0] BaseAddr,
    input  logic [ADDRWIDTH:0]   WordCount,
    input  logic [7:0]           InData,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [ADDRWIDTH-1:0] PortAAddr,
    output logic [DATAWIDTH-1:0] PortADataIn,
    output logic                 PortAWriteEnable,
    input  logic [DATAWIDTH-1:0] PortADataOut,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [15:0]          Checksum
);

    localparam int unsigned BYTES = DATAWIDTH / 8;
    // A single-byte word still needs a 1-bit counter to keep the code legal
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StWrite   = 3'd2,
        StFinish  = 3'd3
`ifdef LOADER_VERIFY_EN
        ,
        StVrd     = 3'd4,
        StVcmp    = 3'd5
`endif
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [ADDRWIDTH-1:0]   r_base;
    logic [ADDRWIDTH:0]     r_count;
    logic [ADDRWIDTH:0]     r_idx;
    logic [BCW-1:0]         r_bcnt;
    logic [DATAWIDTH-1:0]   r_word;
    logic [15:0]            r_checksum;

    logic                   w_start;
    logic                   w_accept;
    logic                   w_last_byte;
    logic                   w_last_word;
    logic [ADDRWIDTH:0]     w_idx_inc;
    logic [ADDRWIDTH-1:0]   w_cur_addr;

    assign w_start     = (r_state == StIdle) && StartLoad;
    assign w_accept    = (r_state == StCollect) && InValid;
    assign w_last_byte = (r_bcnt == BCW'(BYTES - 1));
    assign w_idx_inc   = r_idx + {{ADDRWIDTH{1'b0}}, 1'b1};
    assign w_last_word = (w_idx_inc == r_count);
    // Address arithmetic wraps modulo 2^ADDRWIDTH
    assign w_cur_addr  = r_base + r_idx[ADDRWIDTH-1:0];

    assign Busy        = (r_state != StIdle);
    assign Checksum    = r_checksum;

    // Next-state decode and per-state output strobes
    always_comb begin
        w_state_d        = r_state;
        InReady          = 1'b0;
        PortAWriteEnable = 1'b0;
        PortAAddr        = '0;
        PortADataIn      = '0;
        Done             = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (StartLoad) begin
                    w_state_d = (WordCount == '0) ? StFinish : StCollect;
                end
            end
            StCollect: begin
                InReady = 1'b1;
                if (InValid && w_last_byte) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                PortAWriteEnable = 1'b1;
                PortAAddr        = w_cur_addr;
                PortADataIn      = r_word;
                if (w_last_word) begin
`ifdef LOADER_VERIFY_EN
                    w_state_d = StVrd;
`else
                    w_state_d = StFinish;
`endif
                end else begin
                    w_state_d = StCollect;
                end
            end
`ifdef LOADER_VERIFY_EN
            StVrd: begin
                PortAAddr = w_cur_addr;
                w_state_d = StVcmp;
            end
            StVcmp: begin
                w_state_d = w_last_word ? StFinish : StVrd;
            end
`endif
            StFinish: begin
                Done      = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register plus load datapath: word packing, index and checksum
    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            r_state    <= StIdle;
            r_base     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_word     <= '0;
            r_checksum <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_start) begin
                r_base     <= BaseAddr;
                r_count    <= WordCount;
                r_idx      <= '0;
                r_bcnt     <= '0;
                r_checksum <= '0;
            end
            if (w_accept) begin
                r_word[{r_bcnt, 3'b000} +: 8] <= InData;
                r_checksum <= r_checksum + {8'h00, InData};
                r_bcnt     <= w_last_byte ? '0 : r_bcnt + BCW'(1);
            end
            if (r_state == StWrite) begin
                // Restart the index at zero so the verify pass walks the same range
                r_idx <= w_last_word ? '0 : w_idx_inc;
            end
`ifdef LOADER_VERIFY_EN
            if (r_state == StVcmp) begin
                r_idx <= w_idx_inc;
            end
`endif
        end
    end

`ifdef LOADER_VERIFY_EN
    logic [15:0] r_rb_sum;
    logic [15:0] w_rb_next;
    logic        r_error;

    // Read-back sum including the word currently on PortADataOut
    always_comb begin
        w_rb_next = r_rb_sum;
        for (int k = 0; k < BYTES; k++) begin
            w_rb_next = w_rb_next + {8'h00, PortADataOut[8*k +: 8]};
        end
    end

    // Read-back accumulator and sticky mismatch flag
    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            r_rb_sum <= '0;
            r_error  <= 1'b0;
        end else if (w_start) begin
            r_rb_sum <= '0;
            r_error  <= 1'b0;
        end else if (r_state == StVcmp) begin
            r_rb_sum <= w_rb_next;
            if (w_last_word && (w_rb_next != r_checksum)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign Error = r_error;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^PortADataOut;
    assign Error          = 1'b0;
`endif

endmodule
